predictor_scheduler: RTL and testbench
======================================

Name: predictor_scheduler

Overview:
- Owns a table of 2-bit saturating branch counters, 2^IDX_W entries.
- Shares the table's single access slot per cycle between two lookup requesters (fetch ports 0/1) and one resolve/update port.
- Sits between the fetch stage and branch resolution. Initialises the table after reset and returns registered predictions tagged with the requester id.

Parameters:
- IDX_W, 4, table index width; table depth = 2^IDX_W.
- STARVE_MAX, 4, consecutive cycles a pending lookup may lose to updates before it is forced through.
- INIT_VAL, 2'b01, counter value written to every entry during initialisation (weakly not-taken).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- lk0_valid  in  1  port-0 lookup request.
- lk0_index  in  IDX_W  port-0 table index.
- lk0_ready  out  1  port-0 lookup accepted this cycle.
- lk1_valid  in  1  port-1 lookup request.
- lk1_index  in  IDX_W  port-1 table index.
- lk1_ready  out  1  port-1 lookup accepted this cycle.
- upd_valid  in  1  resolved-branch update request.
- upd_index  in  IDX_W  index to update.
- upd_taken  in  1  actual branch outcome.
- upd_ready  out  1  update accepted this cycle.
- resp_valid  out  1  prediction response valid.
- resp_id  out  1  requester id of the response (0/1).
- resp_prediction  out  1  MSB of the counter read (1 = taken).
- init_done  out  1  high once table initialisation completes.

Behaviour:
- Reset (async, rst=1):
  - state=INIT, init pointer=0, rr_ptr=0, starve counter=0.
  - resp_valid=0, resp_id=0, resp_prediction=0, init_done=0.
  - All readies 0.
- State INIT:
  - Writes INIT_VAL to entry[init pointer] each cycle and increments the pointer.
  - After writing entry 2^IDX_W-1, moves to RUN and sets init_done=1. INIT lasts exactly 2^IDX_W cycles.
  - All readies are 0 and resp_valid is 0 throughout INIT.
- State RUN: exactly one grant per cycle. Readies are combinational from valids and state; a transfer occurs when valid&&ready.
- Priority within RUN:
  - An update wins, unless a lookup is pending and starve counter == STARVE_MAX; in that case the lookup wins and the update stalls (upd_ready=0).
  - Between lookups, round-robin: rr_ptr names the preferred port.
  - If only one lookup is valid, that port wins regardless of rr_ptr.
  - After granting lookup port k, rr_ptr = ~k. rr_ptr is unchanged on update grants or idle cycles.
- Starve counter:
  - Increments when any lookup is valid but an update was granted.
  - Clears to 0 on any lookup grant.
  - Holds when no lookup is valid.
  - Saturates at STARVE_MAX.
- Update arithmetic: taken increments the counter and saturates at 3; not-taken decrements it and saturates at 0. The write takes effect at the granting edge.
- Lookup latency:
  - The table is read in the grant cycle. resp_valid/resp_id/resp_prediction are registered and appear exactly 1 cycle after grant.
  - resp_valid is high for one cycle per grant; it is 0 in cycles with no lookup grant.
- Ordering:
  - An update granted in cycle N is visible to a lookup granted in cycle N+1 or later.
  - Update and lookup are never granted in the same cycle, so no read/write collision exists.
- Mid-operation reset: reset during INIT or RUN aborts immediately. The in-flight response is dropped and INIT restarts from entry 0.
- No response backpressure: the consumer must accept resp_* every cycle.

Optional Feature:
- Macro PRED_SCHED_STATS_EN.
- When defined:
  - Adds outputs stat_lookups (16 bits), stat_updates (16 bits) and stat_forced (8 bits).
  - stat_lookups counts lookup grants, stat_updates counts update grants, stat_forced counts starvation-forced lookup grants.
  - All three saturate at all-ones and are cleared by rst.
- When undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset, then idle with IDX_W=4 -> init_done rises after exactly 16 cycles in INIT. A lookup then returns resp_prediction=0 one cycle after grant for every index.
- Update index 3 taken twice, then lookup index 3 on port 0 -> counter goes 01->10->11 and resp_prediction=1, resp_id=0. Three not-taken updates followed by a lookup -> counter is 00 and resp_prediction=0. A fourth not-taken update keeps 00.
- lk0_valid and lk1_valid held high continuously with no updates -> grants alternate 0,1,0,1. resp_id follows the same sequence one cycle later.
- upd_valid held high with lk0_valid high, STARVE_MAX=4 -> 4 update grants, then a forced lk0 grant on the 5th cycle with upd_ready=0. Pattern repeats; stat_forced increments per forced grant when stats are enabled.
- Update index 7 taken granted in cycle N, lookup index 7 granted in cycle N+1 -> the response reflects the updated counter.
- Assert rst mid-RUN with a lookup granted the previous cycle -> resp_valid=0 immediately, init_done=0, readies 0 for 16 cycles. After INIT, previously trained entries read as not-taken.

Source files
------------

// File: rtl/predictor_scheduler.sv
// rtl/predictor_scheduler.sv - 2-bit branch predictor table with lookup/update access scheduling
//
// Purpose: owns 2^IDX_W saturating 2-bit counters. It initialises every
// entry to INIT_VAL after reset, then grants the table's single access slot
// each cycle to one of: the resolve/update port, or one of two fetch lookup
// ports. Lookup responses are registered and tagged with the requester id.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   lk0_valid/index     fetch port 0 lookup request; lk0_ready = accepted
//   lk1_valid/index     fetch port 1 lookup request; lk1_ready = accepted
//   upd_valid/index     resolved-branch update with outcome upd_taken;
//   upd_taken           upd_ready = accepted
//   resp_valid/id/      prediction (counter MSB) one cycle after a lookup
//   resp_prediction     grant, tagged with the winning port id
//   init_done           high once the table has been initialised
//
// Optional feature (macro PRED_SCHED_STATS_EN): adds saturating counters
//   stat_lookups (16b), stat_updates (16b) and stat_forced (8b).
module predictor_scheduler #(
  parameter int         IDX_W      = 4,
  parameter int         STARVE_MAX = 4,
  parameter logic [1:0] INIT_VAL   = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lk0_valid,
  input  logic [IDX_W-1:0] lk0_index,
  output logic             lk0_ready,
  input  logic             lk1_valid,
  input  logic [IDX_W-1:0] lk1_index,
  output logic             lk1_ready,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             resp_valid,
  output logic             resp_id,
  output logic             resp_prediction,
  output logic             init_done
`ifdef PRED_SCHED_STATS_EN
  ,
  output logic [15:0]      stat_lookups,
  output logic [15:0]      stat_updates,
  output logic [7:0]       stat_forced
`endif
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int SW    = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]    SMAX = SW'(STARVE_MAX);
  localparam logic [IDX_W-1:0] LAST = {IDX_W{1'b1}};

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] init_ptr;
  logic             rr_ptr;
  logic [SW-1:0]    starve;
  logic [1:0]       tbl [DEPTH];

  logic             lk_pend;
  logic             forced;
  logic             upd_gnt;
  logic             lk_gnt;
  logic             lk_sel;
  logic [IDX_W-1:0] lk_idx;
  logic [1:0]       upd_cur;
  logic [1:0]       upd_nxt;

  // Arbitration and next state
  always_comb begin
    state_nxt = state;
    upd_gnt   = 1'b0;
    lk_gnt    = 1'b0;
    forced    = 1'b0;
    lk_pend   = lk0_valid | lk1_valid;
    // A lone requester wins regardless of the round-robin pointer.
    if (lk0_valid && lk1_valid) begin
      lk_sel = rr_ptr;
    end else begin
      lk_sel = ~lk0_valid;
    end
    case (state)
      S_INIT: begin
        if (init_ptr == LAST) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // A starved lookup pre-empts the normally higher-priority update.
        forced  = lk_pend && (starve == SMAX);
        upd_gnt = upd_valid && !forced;
        lk_gnt  = lk_pend && !upd_gnt;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  assign lk0_ready = lk_gnt && !lk_sel;
  assign lk1_ready = lk_gnt && lk_sel;
  assign upd_ready = upd_gnt;
  assign lk_idx    = lk_sel ? lk1_index : lk0_index;

  // Saturating counter arithmetic for the update port
  always_comb begin
    upd_cur = tbl[upd_index];
    upd_nxt = upd_cur;
    if (upd_taken) begin
      if (upd_cur != 2'b11) upd_nxt = upd_cur + 2'b01;
    end else begin
      if (upd_cur != 2'b00) upd_nxt = upd_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_INIT;
      init_ptr        <= '0;
      rr_ptr          <= 1'b0;
      starve          <= '0;
      resp_valid      <= 1'b0;
      resp_id         <= 1'b0;
      resp_prediction <= 1'b0;
      init_done       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) begin
        init_ptr <= init_ptr + IDX_W'(1);
        if (state_nxt == S_RUN) init_done <= 1'b1;
      end
      if (lk_gnt) begin
        rr_ptr <= ~lk_sel;
        starve <= '0;
      end else if (upd_gnt && lk_pend && (starve != SMAX)) begin
        starve <= starve + SW'(1);
      end
      resp_valid <= lk_gnt;
      if (lk_gnt) begin
        resp_id         <= lk_sel;
        resp_prediction <= tbl[lk_idx][1];
      end
    end
  end

  // Table storage: no reset, contents are rebuilt by the INIT sweep.
  // Lookups read before the edge, so an update is seen the cycle after.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT) begin
        tbl[init_ptr] <= INIT_VAL;
      end else if (upd_gnt) begin
        tbl[upd_index] <= upd_nxt;
      end
    end
  end

`ifdef PRED_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups <= '0;
      stat_updates <= '0;
      stat_forced  <= '0;
    end else begin
      if (lk_gnt && (stat_lookups != 16'hffff)) stat_lookups <= stat_lookups + 16'd1;
      if (upd_gnt && (stat_updates != 16'hffff)) stat_updates <= stat_updates + 16'd1;
      // Forced only when an update was actually held off by the lookup.
      if (lk_gnt && forced && upd_valid && (stat_forced != 8'hff)) stat_forced <= stat_forced + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_predictor_scheduler.sv
// tb/tb_predictor_scheduler.sv - scoreboard bench for predictor_scheduler
module tb_predictor_scheduler;

  localparam int IDX_W = 4;
  localparam int DEPTH = 16;
  localparam int SMAX  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             lk0_valid, lk1_valid, upd_valid, upd_taken;
  logic [IDX_W-1:0] lk0_index, lk1_index, upd_index;
  logic             lk0_ready, lk1_ready, upd_ready;
  logic             resp_valid, resp_id, resp_prediction, init_done;
`ifdef PRED_SCHED_STATS_EN
  logic [15:0]      stat_lookups, stat_updates;
  logic [7:0]       stat_forced;
`endif

  always #5 clk = ~clk;

  predictor_scheduler #(.IDX_W(IDX_W), .STARVE_MAX(SMAX), .INIT_VAL(2'b01)) dut (
    .clk(clk), .rst(rst),
    .lk0_valid(lk0_valid), .lk0_index(lk0_index), .lk0_ready(lk0_ready),
    .lk1_valid(lk1_valid), .lk1_index(lk1_index), .lk1_ready(lk1_ready),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_ready(upd_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_prediction(resp_prediction),
    .init_done(init_done)
`ifdef PRED_SCHED_STATS_EN
    , .stat_lookups(stat_lookups), .stat_updates(stat_updates), .stat_forced(stat_forced)
`endif
  );

  typedef struct {
    bit id;
    bit pred;
  } resp_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  resp_t exp_q[$];
  resp_t mon_e;

  // Reference model state
  int mtbl[DEPTH];
  int m_starve, m_rr, m_forced, m_lk, m_up;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mtbl[i] = 1;
    m_starve = 0;
    m_rr     = 0;
    m_forced = 0;
    m_lk     = 0;
    m_up     = 0;
    exp_q.delete();
  endtask

  // One RUN cycle: drive, check readies against the model, record expectation.
  task automatic cyc(input int l0v, input int l0i, input int l1v, input int l1i,
                     input int uv, input int ui, input int ut);
    bit         pend, ug, lg;
    int         k, idx;
    logic [2:0] er;
    lk0_valid = (l0v != 0); lk0_index = IDX_W'(l0i);
    lk1_valid = (l1v != 0); lk1_index = IDX_W'(l1i);
    upd_valid = (uv != 0);  upd_index = IDX_W'(ui); upd_taken = (ut != 0);
    #1;
    pend = (l0v != 0) || (l1v != 0);
    ug   = (uv != 0) && !(pend && m_starve == SMAX);
    lg   = pend && !ug;
    k    = ((l0v != 0) && (l1v != 0)) ? m_rr : ((l0v != 0) ? 0 : 1);
    er   = {lg && k == 0, lg && k == 1, ug};
    chk("readies", 32'({lk0_ready, lk1_ready, upd_ready}), 32'(er));
    if (lg) begin
      idx = (k == 0) ? l0i : l1i;
      exp_q.push_back('{id: k[0], pred: (mtbl[idx] >= 2)});
      m_rr     = 1 - k;
      m_starve = 0;
      m_lk++;
      if (uv != 0) m_forced++;
    end else if (ug) begin
      m_up++;
      if (pend && m_starve < SMAX) m_starve++;
      if (ut != 0) mtbl[ui] = (mtbl[ui] == 3) ? 3 : mtbl[ui] + 1;
      else         mtbl[ui] = (mtbl[ui] == 0) ? 0 : mtbl[ui] - 1;
    end
    @(negedge clk);
  endtask

  task automatic init_phase();
    for (int i = 0; i < DEPTH; i++) begin
      lk0_valid = 1'b1; lk0_index = IDX_W'($urandom_range(0, DEPTH - 1));
      lk1_valid = 1'b1; lk1_index = IDX_W'($urandom_range(0, DEPTH - 1));
      upd_valid = 1'b1; upd_index = IDX_W'($urandom_range(0, DEPTH - 1));
      upd_taken = 1'b1;
      #1;
      chk("init_done_low", 32'(init_done), 32'd0);
      chk("init_readies", 32'({lk0_ready, lk1_ready, upd_ready}), 32'd0);
      @(negedge clk);
    end
    chk("init_done_high", 32'(init_done), 32'd1);
    lk0_valid = 1'b0; lk1_valid = 1'b0; upd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lk0_valid = 1'b1; lk1_valid = 1'b1; upd_valid = 1'b1;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_readies", 32'({lk0_ready, lk1_ready, upd_ready}), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    init_phase();
  endtask

  // Monitor: responses are due exactly one cycle after their grant.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst !== 1'b1) begin
        if (resp_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("resp_unexpected", 32'(resp_valid), 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("resp_id", 32'(resp_id), 32'(mon_e.id));
            chk("resp_prediction", 32'(resp_prediction), 32'(mon_e.pred));
          end
        end else if (exp_q.size() != 0) begin
          chk("resp_missing", 32'(resp_valid), 32'd1);
          exp_q.delete();
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    lk0_valid = 1'b0; lk1_valid = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0;
    lk0_index = '0; lk1_index = '0; upd_index = '0;
    do_reset();

    // Every entry reads weakly not-taken after INIT
    for (int i = 0; i < DEPTH; i++) cyc(1, i, 0, 0, 0, 0, 0);

    // Saturating training of entry 3
    repeat (2) cyc(0, 0, 0, 0, 1, 3, 1);
    cyc(1, 3, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 3, 0);
    cyc(1, 3, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 3, 0);
    cyc(0, 0, 1, 3, 0, 0, 0);

    // Round-robin between both lookup ports
    repeat (6) cyc(1, 5, 1, 9, 0, 0, 0);

    // Starvation: continuous update with a pending lookup
    repeat (12) cyc(1, 2, 0, 0, 1, 4, 1);
    repeat (12) cyc(1, 2, 1, 6, 1, 4, 0);

    // Update in cycle N visible to lookup in N+1
    cyc(0, 0, 0, 0, 1, 7, 1);
    cyc(0, 0, 1, 7, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 7, 1);
    cyc(0, 0, 1, 7, 0, 0, 0);

    // Randomised traffic
    repeat (400) cyc($urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
                     $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
                     $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
                     $urandom_range(0, 1));

`ifdef PRED_SCHED_STATS_EN
    chk("stat_lookups", 32'(stat_lookups), 32'(m_lk));
    chk("stat_updates", 32'(stat_updates), 32'(m_up));
    chk("stat_forced", 32'(stat_forced), 32'(m_forced));
`endif

    // Train 3 and 7 strongly taken, then reset with a response in flight
    repeat (3) cyc(0, 0, 0, 0, 1, 3, 1);
    repeat (3) cyc(0, 0, 0, 0, 1, 7, 1);
    cyc(1, 3, 0, 0, 0, 0, 0);
    do_reset();
    cyc(1, 3, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 7, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
